// File: rtl/mod_addsub_pipe_if.sv
// mod_addsub_pipe_if: handshake and data bundle for the modular add/sub pipeline.
// The master side drives the input transaction and out_ready.
// The slave side (the pipeline) drives in_ready and the result transaction.
interface mod_addsub_pipe_if #(
   parameter int WIDTH = 24,
   parameter int LANES = 4
);

   logic                     in_valid;
   logic                     in_ready;
   logic                     in_op;
   logic [WIDTH-1:0]         in_q;
   logic [LANES*WIDTH-1:0]   in_a;
   logic [LANES*WIDTH-1:0]   in_b;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*WIDTH-1:0]   out_res;
   logic [LANES-1:0]         out_err;

   modport master (
      output in_valid, in_op, in_q, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_res, out_err
   );

   modport slave (
      input  in_valid, in_op, in_q, in_a, in_b, out_ready,
      output in_ready, out_valid, out_res, out_err
   );

endinterface

// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe: two-stage, multi-lane modular adder/subtractor with
// valid/ready flow control on both sides.
//   S1 holds the raw WIDTH+1 bit sum or difference of every lane, plus op and modulus.
//   S2 holds the corrected, WIDTH bit result of every lane.
// Optional feature macro: MOD_ADDSUB_RANGE_CHECK_EN. When it is defined, out_err[i]
// flags lane i operands that were >= q at acceptance. When it is undefined,
// out_err is constant zero and no range comparators are built.
module mod_addsub_pipe #(
   parameter int WIDTH = 24,
   parameter int LANES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   mod_addsub_pipe_if.slave bus
);

   logic                          s1_valid_q, s1_valid_d;
   logic                          s1_op_q, s1_op_d;
   logic [WIDTH-1:0]              s1_mod_q, s1_mod_d;
   logic [LANES-1:0][WIDTH:0]     s1_raw_q, s1_raw_d;
   logic [LANES-1:0]              s1_err_q, s1_err_d;

   logic                          s2_valid_q, s2_valid_d;
   logic [LANES-1:0][WIDTH-1:0]   s2_res_q, s2_res_d;
   logic [LANES-1:0]              s2_err_q, s2_err_d;

   logic                          s1_load;
   logic                          s2_load;
   logic                          in_accept;

   logic [LANES-1:0][WIDTH-1:0]   lane_a;
   logic [LANES-1:0][WIDTH-1:0]   lane_b;
   logic [LANES-1:0][WIDTH:0]     lane_raw;
   logic [LANES-1:0]              lane_err;
   logic [LANES-1:0][WIDTH-1:0]   lane_corr;

   // Per-lane datapath. Lanes share only op and q, so no carry crosses a lane.
   // The subtract borrow is kept in bit WIDTH of the raw value. The correction
   // adds or removes q modulo 2^WIDTH, which is the same as working in WIDTH+1
   // bits and truncating.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_a[i]   = bus.in_a[i*WIDTH +: WIDTH];
      assign lane_b[i]   = bus.in_b[i*WIDTH +: WIDTH];
      assign lane_raw[i] = bus.in_op ? ({1'b0, lane_a[i]} - {1'b0, lane_b[i]})
                                     : ({1'b0, lane_a[i]} + {1'b0, lane_b[i]});
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
      assign lane_err[i] = (lane_a[i] >= bus.in_q) || (lane_b[i] >= bus.in_q);
`else
      assign lane_err[i] = 1'b0;
`endif
      assign lane_corr[i] = s1_op_q
         ? (s1_raw_q[i][WIDTH] ? (s1_raw_q[i][WIDTH-1:0] + s1_mod_q)
                               : s1_raw_q[i][WIDTH-1:0])
         : ((s1_raw_q[i] >= {1'b0, s1_mod_q}) ? (s1_raw_q[i][WIDTH-1:0] - s1_mod_q)
                                              : s1_raw_q[i][WIDTH-1:0]);
   end

   // Flow control: a stage loads when it is empty or its contents move on.
   // Nothing is accepted while reset is held.
   always_comb begin
      s2_load   = !s2_valid_q || bus.out_ready;
      s1_load   = !s1_valid_q || s2_load;
      in_accept = bus.in_valid && s1_load && rst_n;
   end

   // S1 next state: capture raw lane results on accept; otherwise hold.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_mod_d   = s1_mod_q;
      s1_raw_d   = s1_raw_q;
      s1_err_d   = s1_err_q;
      if (s1_load) begin
         s1_valid_d = in_accept;
      end
      if (in_accept) begin
         s1_op_d  = bus.in_op;
         s1_mod_d = bus.in_q;
         s1_raw_d = lane_raw;
         s1_err_d = lane_err;
      end
   end

   // S2 next state: take the corrected result from S1 when S2 loads; otherwise hold.
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      s2_err_d   = s2_err_q;
      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_res_d = lane_corr;
            s2_err_d = s1_err_q;
         end
      end
   end

   // Pipeline registers. Reset discards everything in flight immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= 1'b0;
         s1_mod_q   <= '0;
         s1_raw_q   <= '0;
         s1_err_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_err_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_mod_q   <= s1_mod_d;
         s1_raw_q   <= s1_raw_d;
         s1_err_q   <= s1_err_d;
         s2_valid_q <= s2_valid_d;
         s2_res_q   <= s2_res_d;
         s2_err_q   <= s2_err_d;
      end
   end

   assign bus.in_ready  = s1_load && rst_n;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_res   = s2_res_q;
   assign bus.out_err   = s2_err_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// tb_mod_addsub_pipe: randomized and directed stimulus for mod_addsub_pipe,
// checked against a transaction-level reference model (queue of expected results).
module tb_mod_addsub_pipe;

   localparam int WIDTH = 24;
   localparam int LANES = 4;
   localparam int LW    = WIDTH * LANES;
   localparam logic [WIDTH-1:0] QDIL = 24'd8380417;

   logic clk;
   logic rst_n;

   mod_addsub_pipe_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

   mod_addsub_pipe #(.WIDTH(WIDTH), .LANES(LANES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [LW-1:0]    res;
      logic [LANES-1:0] err;
      logic             chk;
      int               cyc;
   } exp_t;

   exp_t expQ[$];
   int   testCount;
   int   failCount;
   int   cycleNum;

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycleNum);
      end
   endtask

   // Reference for a single lane, written straight from the arithmetic definition.
   // In-range operands give the true modular result; otherwise the raw formula is
   // applied and then truncated.
   function automatic logic [WIDTH-1:0] refLane(input logic op, input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      longint la, lb, lq, r;
      la = longint'(a);
      lb = longint'(b);
      lq = longint'(q);
      if (la < lq && lb < lq)
         r = op ? ((la - lb + lq) % lq) : ((la + lb) % lq);
      else if (op)
         r = (la >= lb) ? (la - lb) : (la - lb + lq);
      else
         r = (la + lb >= lq) ? (la + lb - lq) : (la + lb);
      return r[WIDTH-1:0];
   endfunction

   // One clock cycle. Inputs are already applied at the falling edge. Outputs are
   // checked against the model, then the transfers that happen at the coming
   // rising edge are applied to the model.
   task automatic tick();
      exp_t             e;
      logic             expValid;
      logic [WIDTH-1:0] la, lb;
      #1;
      checkOutput("in_ready", bus.in_ready, (expQ.size() < 2) || bus.out_ready);
      expValid = (expQ.size() > 0) && (cycleNum - expQ[0].cyc >= 2);
      checkOutput("out_valid", bus.out_valid, expValid);
      if (expValid) begin
         if (expQ[0].chk) checkOutput("out_res", bus.out_res, expQ[0].res);
         checkOutput("out_err", bus.out_err, expQ[0].err);
         if (bus.out_ready) void'(expQ.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
         for (int i = 0; i < LANES; i++) begin
            la = bus.in_a[i*WIDTH +: WIDTH];
            lb = bus.in_b[i*WIDTH +: WIDTH];
            e.res[i*WIDTH +: WIDTH] = refLane(bus.in_op, bus.in_q, la, lb);
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
            e.err[i] = (la >= bus.in_q) || (lb >= bus.in_q);
`else
            e.err[i] = 1'b0;
`endif
         end
         e.chk = (bus.in_q != '0);
         e.cyc = cycleNum;
         expQ.push_back(e);
      end
      cycleNum++;
      @(negedge clk);
   endtask

   // Drive one cycle of input stimulus, then advance the clock.
   task automatic applyStimulus(input logic v, input logic op, input logic [WIDTH-1:0] q,
                                input logic [LW-1:0] a, input logic [LW-1:0] b, input logic ordy);
      bus.in_valid  = v;
      bus.in_op     = op;
      bus.in_q      = q;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.out_ready = ordy;
      tick();
   endtask

   // Random lane operands, mostly below q, occasionally arbitrary.
   task automatic randomOperands(input logic [WIDTH-1:0] q, output logic [LW-1:0] a,
                                 output logic [LW-1:0] b);
      for (int i = 0; i < LANES; i++) begin
         if ($urandom_range(0, 7) == 0) a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         else                           a[i*WIDTH +: WIDTH] = WIDTH'($urandom % q);
         if ($urandom_range(0, 7) == 0) b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         else                           b[i*WIDTH +: WIDTH] = WIDTH'($urandom % q);
      end
   endtask

   // Main sequence.
   initial begin
      logic [LW-1:0]    ra, rb;
      logic [WIDTH-1:0] rq;
      testCount     = 0;
      failCount     = 0;
      cycleNum      = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = 1'b0;
      bus.in_q      = QDIL;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_out_valid", bus.out_valid, 1'b0);
      checkOutput("rst_out_res", bus.out_res, '0);
      checkOutput("rst_out_err", bus.out_err, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // Add corner values, then a gap so that the result shows up exactly 2 cycles later.
      applyStimulus(1'b1, 1'b0, QDIL, {24'd0, 24'd8380416, 24'd100, 24'd8380416},
                    {24'd0, 24'd0, 24'd200, 24'd1}, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, QDIL, '0, '0, 1'b1);

      // Subtract corner values, including a < b wrap and zero operands.
      applyStimulus(1'b1, 1'b1, QDIL, {24'd8380416, 24'd0, 24'd7, 24'd5},
                    {24'd0, 24'd0, 24'd5, 24'd7}, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, QDIL, '0, '0, 1'b1);

      // Lane 2 operand equal to q: the range flag, if enabled, shows on lane 2 only.
      applyStimulus(1'b1, 1'b0, QDIL, {24'd9, QDIL, 24'd3, 24'd1},
                    {24'd2, 24'd3, 24'd4, 24'd5}, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, QDIL, '0, '0, 1'b1);

      // Zero modulus: only the handshake is checked.
      applyStimulus(1'b1, 1'b0, '0, {24'd1, 24'd2, 24'd3, 24'd4},
                    {24'd5, 24'd6, 24'd7, 24'd8}, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, QDIL, '0, '0, 1'b1);

      // 16 back-to-back transactions with mixed op and downstream always ready.
      for (int n = 0; n < 16; n++) begin
         randomOperands(QDIL, ra, rb);
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), QDIL, ra, rb, 1'b1);
      end
      repeat (3) applyStimulus(1'b0, 1'b0, QDIL, '0, '0, 1'b1);

      // Downstream stalls for 5 cycles under continuous input, then releases.
      for (int n = 0; n < 5; n++) begin
         randomOperands(QDIL, ra, rb);
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), QDIL, ra, rb, 1'b0);
      end
      for (int n = 0; n < 4; n++) begin
         randomOperands(QDIL, ra, rb);
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), QDIL, ra, rb, 1'b1);
      end
      repeat (3) applyStimulus(1'b0, 1'b0, QDIL, '0, '0, 1'b1);

      // Fill both stages, then assert reset between clock edges.
      for (int n = 0; n < 3; n++) begin
         randomOperands(QDIL, ra, rb);
         applyStimulus(1'b1, 1'b0, QDIL, ra, rb, 1'b0);
      end
      #2;
      checkOutput("pre_rst_out_valid", bus.out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_out_valid", bus.out_valid, 1'b0);
      checkOutput("async_rst_out_res", bus.out_res, '0);
      expQ.delete();
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b1, QDIL, {24'd40, 24'd30, 24'd20, 24'd10},
                    {24'd1, 24'd2, 24'd3, 24'd4}, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, QDIL, '0, '0, 1'b1);

      // Random traffic on both sides with assorted moduli.
      for (int n = 0; n < 300; n++) begin
         rq = ($urandom_range(0, 1) == 1) ? QDIL : (WIDTH'($urandom) | 24'd1);
         randomOperands(rq, ra, rb);
         applyStimulus(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), rq, ra, rb,
                       1'($urandom_range(0, 9) < 7));
      end

      // Drain whatever is still in flight, with a bounded cycle budget.
      for (int n = 0; n < 10; n++) begin
         if (expQ.size() != 0) applyStimulus(1'b0, 1'b0, QDIL, '0, '0, 1'b1);
      end
      checkOutput("drain_empty", 128'(expQ.size()), '0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/mod_addsub_pipe.md
MOD_ADDSUB_PIPE -- requirements
Module: mod_addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 24: operand, modulus and result width in bits.
REQ-002 Parameter LANES, default 4: number of independent coefficient lanes processed per transaction.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 in_valid  input  1: input transaction present.
REQ-006 in_ready  output  1: block accepts the input transaction this cycle.
REQ-007 in_op  input  1: 0 = modular add, 1 = modular subtract; applies to all lanes.
REQ-008 in_q  input  WIDTH: modulus, sampled with the transaction; travels with it.
REQ-009 in_a, in_b  input  LANES*WIDTH each: lane i occupies bits [i*WIDTH +: WIDTH].
REQ-010 out_valid  output  1: result transaction present.
REQ-011 out_ready  input  1: downstream accepts the result this cycle.
REQ-012 out_res  output  LANES*WIDTH: per-lane result, same lane packing as inputs.
REQ-013 out_err  output  LANES: per-lane range-error flags (see Configuration).

Function
REQ-014 A transaction transfers in when in_valid && in_ready and out when out_valid && out_ready.
REQ-015 Two-stage pipeline: S1 registers raw sum or difference (WIDTH+1 bits) plus op, q; S2 registers the corrected result.
REQ-016 Latency: a transaction accepted in cycle N SHALL appear on out_valid in cycle N+2 when unstalled.
REQ-017 Throughput: one transaction per cycle while out_ready is held high.
REQ-018 S2 loads when S2 is empty or out_ready=1; S1 loads when S1 is empty or S2 loads; in_ready = S1 load condition (combinational from out_ready).
REQ-019 Stalled stages SHALL hold their contents unchanged; out_res and out_err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 Bubbles collapse: an empty S2 SHALL accept from S1 regardless of out_ready.
REQ-021 Add: s = a + b computed in WIDTH+1 bits; res = s - q if s >= q, else s.
REQ-022 Subtract: res = a - b if a >= b, else a - b + q, computed in WIDTH+1 bits, truncated to WIDTH.
REQ-023 For a, b < q, res SHALL equal (a op b) mod q exactly; for a or b >= q, res is the raw formula of REQ-021/022 truncated to WIDTH, no other guarantee.
REQ-024 q = 0 is unsupported; result is unspecified but the handshake SHALL still operate normally.
REQ-025 Simultaneous output pop and input push on a full pipeline SHALL accept the new transaction with no loss or duplication.
REQ-026 Lanes are independent; no carry or state crosses lane boundaries.

Reset
REQ-027 While rst_n=0: S1/S2 valid bits cleared, out_valid=0, out_res=0, out_err=0, in_ready=1 once rst_n releases.
REQ-028 Assertion of rst_n mid-transaction SHALL discard all in-flight transactions immediately, without waiting for a clock edge.
REQ-029 No transaction SHALL be accepted in a cycle where rst_n is low.

Configuration
REQ-030 Macro MOD_ADDSUB_RANGE_CHECK_EN defined: out_err[i] = 1 when lane i had a >= q or b >= q at acceptance; the flag is pipelined alongside its result.
REQ-031 Macro undefined: no comparison logic; out_err tied to 0; all other behaviour identical.

Verification
REQ-032 WIDTH=24, q=8380417, add a=8380416, b=1 -> res=0; a=100, b=200 -> res=300; latency exactly 2 cycles.
REQ-033 Subtract a=5, b=7, q=8380417 -> res=8380415; a=7, b=5 -> res=2; a=b=0 -> res=0.
REQ-034 Stream 16 back-to-back transactions, mixed op, out_ready=1 -> 16 results in order, in_ready constant 1.
REQ-035 out_ready=0 for 5 cycles with in_valid=1 -> in_ready falls after 2 accepts, out_res stable; release -> no loss or duplicate.
REQ-036 Assert rst_n low while both stages valid -> out_valid drops asynchronously to 0; after release the first new transaction emerges after 2 cycles.
REQ-037 With MOD_ADDSUB_RANGE_CHECK_EN, lane 2 a=q -> out_err=4'b0100, other lanes 0; without the macro -> out_err=0.
